// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM state encoding and
// operand helpers. Also imported by the decode stage.
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;
   localparam int unsigned MDU_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   function automatic logic op_is_signed(input mdu_op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_div(input mdu_op_e o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   // Two's-complement magnitude when neg is set, identity otherwise.
   function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] v,
                                                    input logic                 neg);
      return neg ? (-v) : v;
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU).
// One radix-2 step per cycle on operand magnitudes; signs are fixed up when
// the results are registered.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   start, op             begin an operation (sampled in IDLE only), op code
//   src_a, src_b          multiplicand/dividend, multiplier/divisor
//   cancel                abort any operation, no write
//   busy                  operation in progress
//   HILO_write            one-cycle strobe with HI_result/LO_result valid
//   HI_result, LO_result  product high/low word or remainder/quotient
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             HILO_write,
   output logic [WIDTH-1:0] HI_result,
   output logic [WIDTH-1:0] LO_result
);

   localparam int unsigned CNT_W = MDU_CNT_W;

   mdu_state_e           r_state;
   logic [2*WIDTH-1:0]   r_acc;        // {hi, lo}: product or {remainder, quotient}
   logic [WIDTH-1:0]     r_m;          // multiplicand / divisor magnitude
   logic [WIDTH-1:0]     r_a;          // original dividend, for divide-by-zero
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_is_div;
   logic                 r_neg_res;    // negate product / quotient
   logic                 r_neg_rem;    // negate remainder
   logic                 r_b_zero;
   logic                 r_busy;
   logic                 r_hilo_write;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   mdu_op_e              w_op;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_div_hi;
   logic [WIDTH:0]       w_div_diff;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_rem;

   // Operand decode for the IDLE latch.
   always_comb begin
      w_op    = mdu_op_e'(op);
      w_a_neg = op_is_signed(w_op) & src_a[WIDTH-1];
      w_b_neg = op_is_signed(w_op) & src_b[WIDTH-1];
      w_a_mag = mdu_mag(src_a, w_a_neg);
      w_b_mag = mdu_mag(src_b, w_b_neg);
   end

   // One iteration step for each operation class, plus final sign fix-up.
   always_comb begin
      // Shift-add: multiplier sits in the low word and is consumed LSB first.
      w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
      w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

      // Restoring divide: shift next dividend bit into the remainder, trial subtract.
      w_div_hi   = r_acc[2*WIDTH-1:WIDTH-1];
      w_div_diff = w_div_hi - {1'b0, r_m};
      if (!w_div_diff[WIDTH]) begin
         w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_div_next = {r_acc[2*WIDTH-2:0], 1'b0};
      end

      w_prod = r_neg_res ? (-r_acc) : r_acc;
      w_quot = r_neg_res ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_rem  = r_neg_rem ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
   end

   // Control FSM and datapath registers; cancel overrides every state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_acc        <= '0;
         r_m          <= '0;
         r_a          <= '0;
         r_cnt        <= '0;
         r_is_div     <= 1'b0;
         r_neg_res    <= 1'b0;
         r_neg_rem    <= 1'b0;
         r_b_zero     <= 1'b0;
         r_busy       <= 1'b0;
         r_hilo_write <= 1'b0;
         r_hi         <= '0;
         r_lo         <= '0;
      end else begin
         r_hilo_write <= 1'b0;
         if (cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_state   <= ST_CALC;
                     r_busy    <= 1'b1;
                     r_cnt     <= '0;
                     r_is_div  <= op_is_div(w_op);
                     r_neg_res <= w_a_neg ^ w_b_neg;
                     r_neg_rem <= w_a_neg;
                     r_b_zero  <= (src_b == '0);
                     r_a       <= src_a;
                     if (op_is_div(w_op)) begin
                        r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                        r_m   <= w_b_mag;
                     end else begin
                        r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                        r_m   <= w_a_mag;
                     end
                  end
               end
               ST_CALC: begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(WIDTH - 1)) begin
                     r_state <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  r_hilo_write <= 1'b1;
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_cnt        <= '0;
                  if (!r_is_div) begin
                     {r_hi, r_lo} <= w_prod;
                  end else if (r_b_zero) begin
                     r_hi <= r_a;
                     r_lo <= '1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy       = r_busy;
   assign HILO_write = r_hilo_write;
   assign HI_result  = r_hi;
   assign LO_result  = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a plain-arithmetic model.
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic        busy;
   logic        HILO_write;
   logic [31:0] HI_result;
   logic [31:0] LO_result;

   int n_vec = 0;
   int n_err = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .op         (op),
      .src_a      (src_a),
      .src_b      (src_b),
      .cancel     (cancel),
      .busy       (busy),
      .HILO_write (HILO_write),
      .HI_result  (HI_result),
      .LO_result  (LO_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {HI, LO} from 64-bit integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub, res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = '0;
      case (o)
         2'b00: res = 64'(sa * sb);
         2'b01: res = ua * ub;
         2'b10: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {32'(r), 32'(q)};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      return res;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op and check busy/HILO_write every cycle up to the write.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke_done);
      logic [63:0] exp;
      exp = model(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      chk("accept busy/hilo", {62'd0, busy, HILO_write}, 64'd2);
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk); #1;
         if (k < 33) begin
            chk($sformatf("calc busy/hilo k=%0d", k), {62'd0, busy, HILO_write}, 64'd2);
            if (poke_done && k == 32) begin
               @(negedge clk);
               start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
            end
         end else begin
            chk("write busy/hilo", {62'd0, busy, HILO_write}, 64'd1);
            chk($sformatf("result op=%0d a=%h b=%h", o, a, b), {HI_result, LO_result}, exp);
         end
      end
      if (poke_done) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk); #1;
         chk("start in DONE ignored", {62'd0, busy, HILO_write}, 64'd0);
      end
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      logic        seen;

      resetn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", {busy, HILO_write, HI_result, LO_result}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("idle after release", {62'd0, busy, HILO_write}, 64'd0);

      // Directed corner cases, issued back-to-back.
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu max const", {HI_result, LO_result}, 64'hFFFF_FFFE_0000_0001);
      run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
      chk("mult -3*5 const", {HI_result, LO_result}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div -7/2 const", {HI_result, LO_result}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div overflow const", {HI_result, LO_result}, 64'h0000_0000_8000_0000);
      run_op(OP_DIVU,  32'd7, 32'd0, 1'b0);
      chk("divu by zero const", {HI_result, LO_result}, 64'h0000_0007_FFFF_FFFF);
      run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0, 1'b0);
      run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, 1'b1);

      // Cancel in CALC cycle 10, then restart in the following cycle.
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk); #1;
      chk("cancel busy/hilo", {62'd0, busy, HILO_write}, 64'd0);
      @(negedge clk);
      cancel = 1'b0;
      run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
      chk("divu 100/7 const", {HI_result, LO_result}, 64'h0000_0002_0000_000E);

      // Cancel together with start in IDLE: cancel wins.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
      @(posedge clk); #1;
      chk("cancel beats start", {62'd0, busy, HILO_write}, 64'd0);
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;

      // Asynchronous reset at CALC cycle 20.
      @(negedge clk);
      start = 1'b1; op = OP_MULT; src_a = 32'h1234_5678; src_b = 32'h0BAD_F00D;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("async reset outputs", {busy, HILO_write, HI_result, LO_result}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen = seen | HILO_write | busy;
      end
      chk("no activity after reset", {63'd0, seen}, 64'd0);

      // Random operations against the model.
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = 32'($urandom_range(1, 20));
            3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
